// File: rtl/uart_bus_master.sv
// Polled bus initiator for the memory-mapped UART: status read, then a TX write, an RX read,
// or a FIFO flush. One access per state visit; all outputs are registered.
module uart_bus_master #(
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic        flush,
    output logic        busy,
    output logic        err,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        bus_en,
    output logic [3:0]  bus_we
);

    localparam logic [31:0] ADDR_RX   = 32'h0;
    localparam logic [31:0] ADDR_TX   = 32'h4;
    localparam logic [31:0] ADDR_STAT = 32'h8;
    localparam logic [31:0] ADDR_CTRL = 32'hC;
    localparam logic [2:0]  WAIT_INIT = 3'(RD_LAT - 1);
    localparam logic [9:0]  TO_LIMIT  = 10'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StStatReq,
        StStatWait,
        StTxWr,
        StRxRd,
        StRxWait,
        StFlushWr
    } state_e;

    state_e      state;
    logic [2:0]  wait_cnt;
    logic [9:0]  to_cnt;
    logic [9:0]  to_inc;
    logic        last_rx;
    logic        flush_pend;
    logic        rx_ok;
    logic        tx_ok;
    logic        unused_rdata;

    assign rx_ok        = bus_rdata[0] & ~rx_valid;
    assign tx_ok        = tx_valid & ~bus_rdata[3];
    assign to_inc       = (&to_cnt) ? to_cnt : to_cnt + 10'd1;
    assign busy         = (state != StIdle);
    assign unused_rdata = ^bus_rdata[31:8];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= StIdle;
            wait_cnt   <= '0;
            to_cnt     <= '0;
            last_rx    <= 1'b0;
            flush_pend <= 1'b0;
            err        <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            tx_ready   <= 1'b0;
            bus_en     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_we     <= '0;
        end else begin
            // Bus returns to all-zero unless the next state issues an access.
            bus_en    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= '0;
            tx_ready  <= 1'b0;

            if (flush) begin
                flush_pend <= 1'b1;
            end
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (flush_pend) begin
                        state     <= StFlushWr;
                        bus_en    <= 1'b1;
                        bus_addr  <= ADDR_CTRL;
                        bus_we    <= 4'hF;
                        bus_wdata <= 32'h3;
                    end else if (tx_valid || !rx_valid) begin
                        state    <= StStatReq;
                        bus_en   <= 1'b1;
                        bus_addr <= ADDR_STAT;
                    end
                end

                StStatReq: begin
                    state    <= StStatWait;
                    wait_cnt <= WAIT_INIT;
                end

                StStatWait: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else begin
                        if (tx_valid && bus_rdata[3]) begin
                            to_cnt <= to_inc;
                            if (to_inc >= TO_LIMIT) begin
                                err <= 1'b1;
                            end
                        end
                        // On a tie, serve whichever side did not go last.
                        if (rx_ok && (!tx_ok || !last_rx)) begin
                            state    <= StRxRd;
                            bus_en   <= 1'b1;
                            bus_addr <= ADDR_RX;
                        end else if (tx_ok) begin
                            state     <= StTxWr;
                            bus_en    <= 1'b1;
                            bus_addr  <= ADDR_TX;
                            bus_we    <= 4'hF;
                            bus_wdata <= {24'b0, tx_data};
                            tx_ready  <= 1'b1;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end

                StTxWr: begin
                    to_cnt  <= '0;
                    last_rx <= 1'b0;
                    state   <= StIdle;
                end

                StRxRd: begin
                    last_rx  <= 1'b1;
                    wait_cnt <= WAIT_INIT;
                    state    <= StRxWait;
                end

                StRxWait: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else begin
                        rx_data  <= bus_rdata[7:0];
                        rx_valid <= 1'b1;
                        state    <= StIdle;
                    end
                end

                StFlushWr: begin
                    rx_valid   <= 1'b0;
                    flush_pend <= flush;
                    to_cnt     <= '0;
                    state      <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // An RX read is only started with rx_valid low, so a consumer accept never meets a load.
    rx_load_vs_accept: assert property (@(posedge clk) disable iff (!rstn)
        !(state == StRxWait && wait_cnt == 3'd0 && rx_valid && rx_ready));

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: a UART register model with read latency answers the bus,
// stimulus queues expected accesses/bytes/probes and a negedge monitor compares them.
module tb_uart_bus_master;

    localparam int unsigned RD_LAT = 2;
    localparam int K_ERR  = 0;
    localparam int K_BUSY = 1;
    localparam int K_RXV  = 2;
    localparam int K_RST  = 3;
    localparam int K_DONE = 4;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        int          cyc;
    } bus_t;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } rx_t;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } probe_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  tx_data = 8'h0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        err;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_en;
    logic [3:0]  bus_we;

    logic [31:0] stat_val = 32'h0;
    logic [7:0]  rx_base = 8'h0;
    logic [7:0]  rx_cnt;
    logic [31:0] rd_pipe [RD_LAT];
    logic        rd_vld  [RD_LAT];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    bus_t   bus_q[$];
    rx_t    rx_q[$];
    probe_t probe_q[$];

    uart_bus_master #(
        .RD_LAT  (RD_LAT),
        .TIMEOUT (1023)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .flush     (flush),
        .busy      (busy),
        .err       (err),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_en    (bus_en),
        .bus_we    (bus_we)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rstn ? cyc + 1 : 0;

    // Register model: a read issued in cycle t is presented on bus_rdata in cycle t+RD_LAT.
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < int'(RD_LAT); i++) rd_vld[i] <= 1'b0;
            rx_cnt <= 8'h0;
        end else begin
            for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
                rd_pipe[i] <= rd_pipe[i-1];
                rd_vld[i]  <= rd_vld[i-1];
            end
            rd_vld[0] <= bus_en && (bus_we == 4'h0);
            if (bus_en && bus_we == 4'h0) begin
                if (bus_addr == 32'h8) begin
                    rd_pipe[0] <= stat_val;
                end else if (bus_addr == 32'h0) begin
                    rd_pipe[0] <= {24'h0, rx_base + rx_cnt};
                    rx_cnt     <= rx_cnt + 8'h1;
                end else begin
                    rd_pipe[0] <= 32'hDEADBEEF;
                end
            end
        end
    end

    assign bus_rdata = rd_vld[RD_LAT-1] ? rd_pipe[RD_LAT-1] : 32'hDEADBEEF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compares every bus access, every new RX byte and every queued probe.
    initial begin
        bit     prev_en;
        bit     rx_presented;
        probe_t p;
        bus_t   e;
        rx_t    r;
        prev_en      = 1'b0;
        rx_presented = 1'b0;
        forever begin
            @(negedge clk);
            while (probe_q.size() != 0 && probe_q[0].cyc <= cyc) begin
                p = probe_q.pop_front();
                case (p.kind)
                    K_ERR:  chk("err", 64'(err), 64'(p.val[0]));
                    K_BUSY: chk("busy", 64'(busy), 64'(p.val[0]));
                    K_RXV:  chk("rx_valid", 64'(rx_valid), 64'(p.val[0]));
                    K_RST: begin
                        chk("reset_bus", {bus_addr, bus_wdata}, 64'h0);
                        chk("reset_ctl", 64'({bus_en, bus_we, tx_ready, rx_valid, rx_data,
                                              busy, err}), 64'h0);
                    end
                    default: begin
                        chk("bus_q_left", 64'(bus_q.size()), 64'h0);
                        chk("rx_q_left", 64'(rx_q.size()), 64'h0);
                    end
                endcase
            end
            if (rstn) begin
                if (!bus_en) begin
                    chk("idle_bus", {bus_addr, bus_wdata}, 64'h0);
                    chk("idle_we", 64'(bus_we), 64'h0);
                    chk("idle_tx_ready", 64'(tx_ready), 64'h0);
                end else begin
                    chk("back_to_back", 64'(prev_en), 64'h0);
                    if (bus_addr == 32'h8) begin
                        chk("stat_we", 64'(bus_we), 64'h0);
                        chk("stat_wdata", 64'(bus_wdata), 64'h0);
                        chk("stat_tx_ready", 64'(tx_ready), 64'h0);
                    end else if (bus_q.size() == 0) begin
                        chk("unexpected_access_addr", 64'(bus_addr), 64'hFFFF_FFFF);
                    end else begin
                        e = bus_q.pop_front();
                        chk("bus_addr", 64'(bus_addr), 64'(e.addr));
                        chk("bus_we", 64'(bus_we), 64'(e.we));
                        chk("bus_wdata", 64'(bus_wdata), 64'(e.wdata));
                        chk("tx_ready", 64'(tx_ready), 64'(e.addr == 32'h4));
                        if (e.cyc >= 0) chk("bus_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
                if (rx_valid && !rx_presented) begin
                    if (rx_q.size() == 0) begin
                        chk("unexpected_rx_data", 64'(rx_data), 64'h1FF);
                    end else begin
                        r = rx_q.pop_front();
                        chk("rx_data", 64'(rx_data), 64'(r.data));
                        if (r.cyc >= 0) chk("rx_cycle", 64'(cyc), 64'(r.cyc));
                    end
                    rx_presented = 1'b1;
                end
                if (!rx_valid || rx_ready) rx_presented = 1'b0;
            end else begin
                rx_presented = 1'b0;
            end
            prev_en = rstn && bus_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        int guard = 0;
        while (cyc < n && guard < 20000) begin
            tick();
            guard++;
        end
    endtask

    task automatic wait_tx(input int limit);
        int n = 0;
        while (!tx_ready && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic probe(input int kind, input logic [31:0] val);
        probe_t p;
        p.cyc  = cyc;
        p.kind = kind;
        p.val  = val;
        probe_q.push_back(p);
    endtask

    task automatic push_bus(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                            input int c);
        bus_t e;
        e.addr  = a;
        e.we    = w;
        e.wdata = d;
        e.cyc   = c;
        bus_q.push_back(e);
    endtask

    task automatic push_rx(input logic [7:0] d, input int c);
        rx_t r;
        r.data = d;
        r.cyc  = c;
        rx_q.push_back(r);
    endtask

    // Leaves rstn low after one reset edge; the next edge after rstn rises is cycle 1.
    task automatic apply_reset();
        rstn = 1'b0;
        tick();
        probe(K_RST, 32'h0);
    endtask

    initial begin
        tick();
        tick();

        // TX: empty TX FIFO, byte 0x41 written in cycle 4.
        apply_reset();
        stat_val = 32'h4;
        tx_data  = 8'h41;
        tx_valid = 1'b1;
        push_bus(32'h4, 4'hF, 32'h41, 4);
        rstn = 1'b1;
        wait_until(2);
        probe(K_BUSY, 32'h1);
        wait_tx(20);
        tick();
        tx_valid = 1'b0;
        repeat (6) tick();

        // RX: byte 0x33 read in cycle 4, presented in cycle 7, then held without polling.
        apply_reset();
        stat_val = 32'h1;
        rx_base  = 8'h33;
        push_bus(32'h0, 4'h0, 32'h0, 4);
        push_rx(8'h33, 7);
        rstn = 1'b1;
        wait_until(20);
        probe(K_BUSY, 32'h0);
        probe(K_RXV, 32'h1);
        wait_until(40);
        probe(K_BUSY, 32'h0);
        stat_val = 32'h0;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        probe(K_RXV, 32'h0);
        repeat (6) tick();

        // Round-robin: both sides ready on every poll, RX wins the first tie.
        apply_reset();
        stat_val = 32'h5;
        rx_base  = 8'h5A;
        rx_ready = 1'b1;
        tx_data  = 8'hA0;
        tx_valid = 1'b1;
        push_bus(32'h0, 4'h0, 32'h0, 4);
        push_rx(8'h5A, 7);
        push_bus(32'h4, 4'hF, 32'hA0, 11);
        push_bus(32'h0, 4'h0, 32'h0, 16);
        push_rx(8'h5B, 19);
        push_bus(32'h4, 4'hF, 32'hA1, 23);
        rstn = 1'b1;
        wait_tx(40);
        tick();
        tx_data = 8'hA1;
        wait_tx(40);
        tick();
        tx_valid = 1'b0;
        stat_val = 32'h4;
        repeat (8) tick();
        rx_ready = 1'b0;

        // Timeout: TX full for 1023 polls sets err; the byte still goes out afterwards.
        apply_reset();
        stat_val = 32'h8;
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        rstn = 1'b1;
        wait_until(4091);
        probe(K_ERR, 32'h0);
        tick();
        probe(K_ERR, 32'h1);
        push_bus(32'h4, 4'hF, 32'h77, -1);
        stat_val = 32'h4;
        wait_tx(20);
        tick();
        tx_valid = 1'b0;
        probe(K_ERR, 32'h1);
        repeat (6) tick();

        // Flush raised mid-poll: poll completes, CTRL write in cycle 13, rx_valid cleared.
        apply_reset();
        stat_val = 32'h1;
        rx_base  = 8'h99;
        push_bus(32'h0, 4'h0, 32'h0, 4);
        push_rx(8'h99, 7);
        rstn = 1'b1;
        wait_until(8);
        stat_val = 32'h8;
        tx_data  = 8'h10;
        tx_valid = 1'b1;
        wait_until(10);
        flush = 1'b1;
        probe(K_BUSY, 32'h1);
        tick();
        flush = 1'b0;
        push_bus(32'hC, 4'hF, 32'h3, 13);
        wait_until(14);
        probe(K_RXV, 32'h0);
        probe(K_BUSY, 32'h0);
        tx_valid = 1'b0;
        stat_val = 32'h0;
        repeat (6) tick();

        // Reset during RX_WAIT abandons the read; no byte is ever presented.
        apply_reset();
        stat_val = 32'h1;
        rx_base  = 8'h44;
        push_bus(32'h0, 4'h0, 32'h0, 4);
        rstn = 1'b1;
        wait_until(5);
        probe(K_BUSY, 32'h1);
        apply_reset();
        stat_val = 32'h0;
        tick();
        rstn = 1'b1;
        repeat (10) tick();

        probe(K_DONE, 32'h0);
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

Bus initiator for the memory-mapped UART register block. It turns byte-stream requests into polled register accesses: status read, then TX write or RX read, plus FIFO flush. It sits between a core-side byte producer/consumer and the UART's `addr`/`din`/`dout`/`en`/`we` port. It is the only master on that port.

## Interface
- `RD_LAT`, 2: cycles from a read access (`bus_en`=1) to the cycle in which `bus_rdata` holds that read's data; legal range 1..7.
- `TIMEOUT`, 1023: consecutive status polls that find TX full while a TX byte is pending before `err` sets; 10-bit counter.
- `clk` in 1: clock; all logic on rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `tx_data` in 8: byte to send; must be stable while `tx_valid`=1.
- `tx_valid` in 1: TX byte offered.
- `tx_ready` out 1: TX handshake; byte consumed in the cycle where `tx_valid` and `tx_ready` are both 1.
- `rx_data` out 8: received byte, held in a 1-entry register.
- `rx_valid` out 1: `rx_data` valid; held until accepted.
- `rx_ready` in 1: consumer accepts `rx_data`.
- `flush` in 1: pulse; request a clear of both UART FIFOs and the local RX register.
- `busy` out 1: state machine not in IDLE.
- `err` out 1: sticky TX timeout flag; cleared only by reset.
- `bus_addr` out 32: register address: 0x0 RX, 0x4 TX, 0x8 STAT, 0xC CTRL.
- `bus_wdata` out 32: write data.
- `bus_rdata` in 32: read data.
- `bus_en` out 1: access strobe, one cycle per access.
- `bus_we` out 4: byte write enables; 4'hF on writes, 0 on reads.

## Operation
- STAT bits:
  - [3] tx_full
  - [2] tx_empty
  - [1] rx_full
  - [0] rx_valid
- CTRL write: din[0] clears the TX FIFO, din[1] clears the RX FIFO.
- States: IDLE, STAT_REQ, STAT_WAIT, TX_WR, RX_RD, RX_WAIT, FLUSH_WR.
- **IDLE**, priority order:
  - A pending flush goes to FLUSH_WR.
  - Otherwise, if `tx_valid`=1 or `rx_valid`=0, go to STAT_REQ.
  - Otherwise stay in IDLE.
- **STAT_REQ:** `bus_en`=1, `bus_addr`=0x8, `bus_we`=0. Go to STAT_WAIT and load the wait counter with RD_LAT-1.
- **STAT_WAIT:** `bus_en`=0. When the counter reaches 0, sample `bus_rdata` and decide:
  - rx_ok = rdata[0] & ~rx_valid.
  - tx_ok = tx_valid & ~rdata[3].
  - Both true: serve the side not served last, per the `last_rx` bit (round-robin). Reset value of `last_rx` is 0, so RX wins the first tie.
  - Only rx_ok: go to RX_RD.
  - Only tx_ok: go to TX_WR.
  - Neither: go to IDLE.
- **TX_WR:**
  - `bus_en`=1, `bus_addr`=0x4, `bus_we`=4'hF, `bus_wdata`={24'b0, tx_data}, `tx_ready`=1 this cycle only.
  - Clear the timeout counter, set `last_rx`=0, go to IDLE.
- **RX_RD:** `bus_en`=1, `bus_addr`=0x0, `bus_we`=0. Set `last_rx`=1, go to RX_WAIT.
- **RX_WAIT:** after RD_LAT-1 further cycles, load `rx_data`=rdata[7:0] and set `rx_valid`=1. Go to IDLE.
- **FLUSH_WR:**
  - `bus_en`=1, `bus_addr`=0xC, `bus_we`=4'hF, `bus_wdata`=32'h3.
  - Clear `rx_valid`, the flush-pending flag and the timeout counter. Go to IDLE.
- **Flush latching:** a `flush` pulse in any state sets the flush-pending flag. The flag is serviced at the next IDLE; an in-progress access always completes first.
- **Timeout counter:** increments, saturating, each time STAT_WAIT samples tx_full=1 while `tx_valid`=1. When it reaches TIMEOUT, `err` sets. The byte is never dropped; polling continues.
- **RX consumer handshake:** `rx_valid`&`rx_ready` clears `rx_valid` on the next edge. If the RX_WAIT load happens in the same cycle, the load wins: `rx_valid` stays 1 with the new data. This cannot occur by construction and is asserted as a cover-never.
- **Idle bus values:** `bus_addr`, `bus_wdata` and `bus_we` are 0 whenever `bus_en`=0.

## Timing
- **Reset:** all outputs are 0, state IDLE, counters 0, `last_rx`=0, flush-pending=0.
- **TX path:** `tx_valid` sampled in IDLE at edge 0 gives STAT_REQ in cycle 1 and TX_WR in cycle 2+RD_LAT (cycle 4 at default).
- **RX path:** RX_RD in cycle 2+RD_LAT, `rx_valid` high from cycle 3+2·RD_LAT.
- **Poll loop:** an unsuccessful poll takes 2+RD_LAT cycles including its IDLE cycle.
- **Bus rate:** at most one `bus_en` per state visit; never back-to-back accesses.
- **Reset mid-operation:** returns to IDLE the next edge; any partially issued access is abandoned.

## Test plan
- Reset, then STAT returns 0x4, `tx_valid` with 0x41 -> `bus_en` at cycle 4 with addr 0x4, wdata 0x41, we 0xF; `tx_ready` one cycle.
- STAT returns 0x1, RX returns 0x33 -> RX read at addr 0x0; `rx_valid`=1 with `rx_data`=0x33 at cycle 7; no further RX read until `rx_ready`.
- STAT returns 0x5 with `tx_valid` held -> RX, then TX, then RX served alternately (round-robin).
- STAT returns 0x8 forever with `tx_valid` -> `err` rises after the 1023rd poll; `tx_ready` never asserts; STAT then 0x4 -> TX write completes and `err` stays 1.
- `flush` pulse during STAT_WAIT -> access completes, then CTRL write wdata 0x3 to 0xC; `rx_valid` cleared.
- `rstn`=0 in RX_WAIT -> next cycle all outputs 0, state IDLE.
